// File: rtl/orbit_lib_clk_gate_ctrl.sv
// Idle-detect enable controller for orbit_lib_clock_gating, clocked on the free-running clock.
// Optional ORBIT_CG_CTRL_STATS_EN adds a saturating count of gated cycles on o_gated_cycles.
module orbit_lib_clk_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_busy,
    input  logic        i_force_on,
    input  logic        i_wake_req,
    output logic        o_wake_ack,
    output logic        o_clk_en,
    output logic        o_gated,
    output logic [15:0] o_gated_cycles
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_IDLE = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_t;

    state_t              state;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [WAKE_W-1:0]   wake_cnt;
    logic                activity;

    assign activity = i_busy | i_force_on | i_wake_req;

    // Enable and gated status only change on OFF entry/exit, so they are updated on those transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ON;
            idle_cnt   <= '0;
            wake_cnt   <= '0;
            o_clk_en   <= 1'b1;
            o_gated    <= 1'b0;
            o_wake_ack <= 1'b0;
        end else begin
            o_wake_ack <= i_wake_req &
                          (o_wake_ack | (state == ST_ON) | (state == ST_IDLE));

            case (state)
                ST_ON: begin
                    if (!activity) begin
                        state    <= ST_IDLE;
                        idle_cnt <= '0;
                    end
                end

                ST_IDLE: begin
                    if (activity) begin
                        state    <= ST_ON;
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_LAST) begin
                        // A still-high ack holds the count here until the handshake closes.
                        if (!o_wake_ack) begin
                            state    <= ST_OFF;
                            idle_cnt <= '0;
                            o_clk_en <= 1'b0;
                            o_gated  <= 1'b1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                ST_OFF: begin
                    if (activity) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                        o_clk_en <= 1'b1;
                        o_gated  <= 1'b0;
                    end
                end

                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= ST_ON;
                        wake_cnt <= '0;
                        idle_cnt <= '0;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= ST_ON;
                    idle_cnt <= '0;
                    wake_cnt <= '0;
                    o_clk_en <= 1'b1;
                    o_gated  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ORBIT_CG_CTRL_STATS_EN
    logic [15:0] gated_cnt;

    // Counts cycles with o_gated high, sticking at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            gated_cnt <= 16'd0;
        end else if (o_gated && (gated_cnt != 16'hFFFF)) begin
            gated_cnt <= gated_cnt + 16'd1;
        end
    end

    assign o_gated_cycles = gated_cnt;
`else
    assign o_gated_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_orbit_lib_clk_gate_ctrl.sv
// Self-checking bench for orbit_lib_clk_gate_ctrl: directed scenarios plus constrained-random
// traffic, all checked against a run-length based reference model.
module tb_orbit_lib_clk_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_busy;
    logic        i_force_on;
    logic        i_wake_req;
    logic        o_wake_ack;
    logic        o_clk_en;
    logic        o_gated;
    logic [15:0] o_gated_cycles;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: gated flag, remaining wake cycles, length of the current idle run.
    bit mOff;
    int mWakeLeft;
    int mIdleRun;
    bit mAck;
    int mGatedCount;

    orbit_lib_clk_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_busy        (i_busy),
        .i_force_on    (i_force_on),
        .i_wake_req    (i_wake_req),
        .o_wake_ack    (o_wake_ack),
        .o_clk_en      (o_clk_en),
        .o_gated       (o_gated),
        .o_gated_cycles(o_gated_cycles)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit b, input bit f, input bit w, input bit r);
        bit act;
        bit normal;
        bit hadAck;
        act = b | f | w;
        if (r) begin
            mOff        = 1'b0;
            mWakeLeft   = 0;
            mIdleRun    = 0;
            mAck        = 1'b0;
            mGatedCount = 0;
            return;
        end
`ifdef ORBIT_CG_CTRL_STATS_EN
        if (mOff && mGatedCount < 65535) mGatedCount++;
`endif
        normal = !mOff && (mWakeLeft == 0);
        hadAck = mAck;
        mAck   = w && (mAck || normal);
        if (mOff) begin
            if (act) begin
                mOff      = 1'b0;
                mWakeLeft = WAKE_CYCLES;
                mIdleRun  = 0;
            end
        end else if (mWakeLeft > 0) begin
            mWakeLeft--;
            mIdleRun = 0;
        end else if (act) begin
            mIdleRun = 0;
        end else begin
            mIdleRun++;
            if (mIdleRun >= IDLE_CYCLES + 1 && !hadAck) begin
                mOff     = 1'b1;
                mIdleRun = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit b, input bit f, input bit w, input bit r);
        i_busy     = b;
        i_force_on = f;
        i_wake_req = w;
        reset      = r;
        @(posedge clk);
        modelStep(b, f, w, r);
        #1;
        checkOutput("model_clk_en", {31'd0, o_clk_en}, {31'd0, !mOff});
        checkOutput("model_gated", {31'd0, o_gated}, {31'd0, mOff});
        checkOutput("model_wake_ack", {31'd0, o_wake_ack}, {31'd0, mAck});
        checkOutput("model_gated_cycles", {16'd0, o_gated_cycles}, mGatedCount);
    endtask

    initial begin
        bit reqOn;
        bit b;
        bit f;
        bit r;

        i_busy = 0; i_force_on = 0; i_wake_req = 0; reset = 1;
        mOff = 0; mWakeLeft = 0; mIdleRun = 0; mAck = 0; mGatedCount = 0;

        // Reset values
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("reset_clk_en", {31'd0, o_clk_en}, 32'd1);
        checkOutput("reset_ack", {31'd0, o_wake_ack}, 32'd0);
        checkOutput("reset_gated", {31'd0, o_gated}, 32'd0);
        checkOutput("reset_gated_cycles", {16'd0, o_gated_cycles}, 32'd0);

        // Gate-off latency: enabled through cycle 4, off from cycle 5
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("gateoff_clk_en", {31'd0, o_clk_en}, (k <= 4) ? 32'd1 : 32'd0);
        end
        checkOutput("gateoff_gated", {31'd0, o_gated}, 32'd1);

        // One-cycle busy pulse from OFF: wake, return to ON, then regate
        applyStimulus(1, 0, 0, 0);
        checkOutput("busywake_clk_en_t1", {31'd0, o_clk_en}, 32'd1);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("busywake_clk_en", {31'd0, o_clk_en}, (k < 8) ? 32'd1 : 32'd0);
            checkOutput("busywake_ack", {31'd0, o_wake_ack}, 32'd0);
        end

        // Held wake request from OFF: ack at t+4, no gating while held
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("wakereq_ack", {31'd0, o_wake_ack}, (k >= 4) ? 32'd1 : 32'd0);
            checkOutput("wakereq_clk_en", {31'd0, o_clk_en}, 32'd1);
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(0, 0, 1, 0);
            checkOutput("wakehold_ack", {31'd0, o_wake_ack}, 32'd1);
            checkOutput("wakehold_clk_en", {31'd0, o_clk_en}, 32'd1);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("wakedrop_ack", {31'd0, o_wake_ack}, 32'd0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 0, 0, 0);

        // Busy exactly on the last idle count cancels gating and restarts the count
        applyStimulus(0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("lastcount_clk_en", {31'd0, o_clk_en}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("restart_clk_en", {31'd0, o_clk_en}, (k <= 4) ? 32'd1 : 32'd0);
        end

        // Reset while in WAKE with a pending request
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("wakereset_clk_en", {31'd0, o_clk_en}, 32'd1);
        checkOutput("wakereset_ack", {31'd0, o_wake_ack}, 32'd0);
        checkOutput("wakereset_gated", {31'd0, o_gated}, 32'd0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("wakereset_on_ack", {31'd0, o_wake_ack}, 32'd1);
        applyStimulus(0, 0, 0, 0);

        // Force-on holds the clock enabled indefinitely
        for (int k = 0; k < 40; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("force_clk_en", {31'd0, o_clk_en}, 32'd1);
        end

        // Randomized traffic with a well-behaved 4-phase requester
        reqOn = 0;
        for (int k = 0; k < 4000; k++) begin
            if (!reqOn && !mAck && $urandom_range(0, 59) == 0) reqOn = 1;
            else if (reqOn && mAck && $urandom_range(0, 3) == 0) reqOn = 0;
            b = ($urandom_range(0, 15) == 0);
            f = ($urandom_range(0, 199) == 0);
            r = ($urandom_range(0, 599) == 0);
            if (r) reqOn = 0;
            applyStimulus(b, f, reqOn, r);
        end

        // Statistics counter
        applyStimulus(0, 0, 0, 1);
`ifdef ORBIT_CG_CTRL_STATS_EN
        for (int k = 0; k < 70010; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("stats_saturate", {16'd0, o_gated_cycles}, 32'h0000FFFF);
`else
        for (int k = 0; k < 200; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("stats_tied_zero", {16'd0, o_gated_cycles}, 32'd0);
`endif
        checkOutput("stats_gated", {31'd0, o_gated}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
